fft_r22sdf_twiddle_gen: RTL and testbench
=========================================

Name: fft_r22sdf_twiddle_gen

Overview:
Twiddle-factor source for one R2^2 SDF twiddle-multiply stage. It consumes the stage sample counter and produces W = exp(-j*2*pi*e/FFT_N) in signed fixed point. It sits upstream of the stage's complex multiplier, which consumes (ctr, w_re, w_im) in the same cycle.
Exponents follow R2^2 ordering and are computed on the fly. Values come from a cosine ROM read through a registered pipeline, with the counter delayed to match.

Parameters:
TWIDDLE_WIDTH, 10, signed width of w_re_o/w_im_o; scale 2^(TWIDDLE_WIDTH-1)
FFT_N, 1024, points in this stage's butterfly section; power of 4, >= 16
NLOG2, 10, log2(FFT_N); width of counters
ROM_INIT_FILE, "", hex init file for the cosine ROM; empty means the ROM is computed at elaboration

Ports:
clk_i  in  1  stage clock
rst_n  in  1  synchronous, active-low reset
valid_i  in  1  ctr_i is meaningful this cycle
ctr_i  in  NLOG2  sample index n within section, 0..FFT_N-1
valid_o  out  1  valid_i delayed by LATENCY
ctr_o  out  NLOG2  ctr_i delayed by LATENCY, aligned with w_*
w_re_o  out  TWIDDLE_WIDTH  Re(W), signed
w_im_o  out  TWIDDLE_WIDTH  Im(W), signed

Behaviour:
- Reset is synchronous and active-low on clk_i (rst_n, clk_i), as already decided.
- Reset values: valid_o=0, ctr_o=0, w_re_o=2^(TW-1)-1, w_im_o=0 (W=1). All pipeline registers clear.
- Reset mid-operation: in-flight entries are discarded. valid_o is low from the cycle after rst_n is sampled low until LATENCY cycles after the first valid_i following release.
- Pipeline is free-running: no stall; one new ctr accepted every cycle. LATENCY = 3 clk_i cycles.
- Valid gating: valid_i low still propagates; ctr_o and w_* are don't-care when valid_o=0.
- S1, exponent:
  - q = n[NLOG2-1:NLOG2-2], m = n mod (FFT_N/4).
  - Map q through bitrev2: 0->0, 1->2, 2->1, 3->3.
  - e = m * bitrev2(q), computed by shift/add only (no multiplier); max 3*(FFT_N/4-1) < FFT_N.
  - Register e and the quadrant qe = e[NLOG2-1:NLOG2-2].
  - Register r = e mod (FFT_N/4).
- S2, ROM read: table C[k] = round(cos(2*pi*k/FFT_N) * 2^(TW-1)), k = 0..FFT_N/4, i.e. FFT_N/4+1 entries. Read A = C[r] and B = C[FFT_N/4 - r] (two read ports). Register A, B, qe.
- S3, fold and register outputs:
  - qe=0: re=A, im=-B
  - qe=1: re=-B, im=-A
  - qe=2: re=-A, im=B
  - qe=3: re=B, im=A
- Arithmetic rules:
  - C[0] = 2^(TW-1) saturates to 2^(TW-1)-1.
  - Negation of the saturated value yields -(2^(TW-1)-1); output is never -2^(TW-1).
  - Rounding is to nearest, ties away from zero.
  - r=0 boundary: B reads C[FFT_N/4]=0; sign fold gives 0, never a negative zero code.
- ctr wrap: ctr_i may jump from FFT_N-1 to 0; there are no inter-sample dependencies.

Optional Feature:
FFT_TWIDDLE_FULL_ROM_EN
- Defined: no quadrant fold. ROM holds FFT_N complex entries {re,im} indexed directly by e. S2 reads one word; S3 only registers it. LATENCY remains 3 and outputs are bit-identical.
- Undefined: quarter-wave ROM with fold, as in Behaviour.

Decomposition:
- Shared package fft_r22sdf_pkg holds:
  - twiddle scale/saturation constants
  - the bitrev2 function
  - a LATENCY constant for this block, so the multiplier stage can align
  - the elaboration-time cosine generator function
- Natural sub-module: fft_twiddle_rom. It is a synchronous-read ROM, dual-port for the quarter table and single-port for the full table, and is selected by the macro.

Test Plan:
- FFT_N=16, TW=10, reset released, valid_i=1, ctr_i=0 -> 3 cycles later valid_o=1, ctr_o=0, w=(511,0).
- ctr_i=5 (m=1, q=1, e=2) -> w=(362,-362).
- ctr_i=13 (e=3) -> w=(196,-473); ctr_i=7 (e=6) -> w=(-362,-362); ctr_i=15 (e=9) -> w=(-473,196).
- Stream ctr 0..15 back-to-back, then wrap to 0 -> every output matches a double-precision model rounded per rules; ctr_o = ctr_i three cycles earlier; no bubble at the wrap.
- Assert rst_n low for one cycle mid-stream -> next cycle valid_o=0, w=(511,0), ctr_o=0; first valid output appears 3 cycles after valid_i resumes.
- Build with and without FFT_TWIDDLE_FULL_ROM_EN, FFT_N=64, all ctr -> output traces identical cycle-for-cycle.

Source files
------------

// File: rtl/fft_r22sdf_pkg.sv
// Shared definitions for the R2^2 SDF twiddle path: twiddle scale and
// saturation helpers, the radix-2 digit reversal, the block latency and the
// elaboration-time cosine table generator.
package fft_r22sdf_pkg;

  // Cycles from ctr_i to the matching (ctr_o, w_re_o, w_im_o).
  localparam int LATENCY = 3;

  localparam real PI = 3.14159265358979323846;

  // Full-scale weight of a twiddle of width tw (the value +1.0 maps to).
  function automatic int tw_scale(input int tw);
    return 1 << (tw - 1);
  endfunction

  // Largest representable positive twiddle; +1.0 saturates here.
  function automatic int tw_max(input int tw);
    return (1 << (tw - 1)) - 1;
  endfunction

  // Two-bit digit reversal used by the R2^2 exponent ordering.
  function automatic logic [1:0] bitrev2(input logic [1:0] q);
    return {q[0], q[1]};
  endfunction

  // round(cos(2*pi*k/n) * 2^(tw-1)), ties away from zero, saturated to tw_max.
  function automatic int cos_entry(input int k, input int n, input int tw);
    real x;
    int  v;
    x = $cos(2.0 * PI * real'(k) / real'(n)) * real'(tw_scale(tw));
    if (x >= 0.0) v = $rtoi($floor(x + 0.5));
    else          v = -$rtoi($floor(-x + 0.5));
    if (v > tw_max(tw)) v = tw_max(tw);
    return v;
  endfunction

  // Real part of W^e rebuilt from the quarter-wave table with the same fold
  // the hardware applies, so a full table is bit-identical to the folded path.
  function automatic int full_re(input int e, input int n, input int tw);
    int qn;
    int r;
    int a;
    int b;
    qn = n / 4;
    r  = e % qn;
    a  = cos_entry(r, n, tw);
    b  = cos_entry(qn - r, n, tw);
    case (e / qn)
      0:       return a;
      1:       return -b;
      2:       return -a;
      default: return b;
    endcase
  endfunction

  // Imaginary part of W^e, same fold as full_re.
  function automatic int full_im(input int e, input int n, input int tw);
    int qn;
    int r;
    int a;
    int b;
    qn = n / 4;
    r  = e % qn;
    a  = cos_entry(r, n, tw);
    b  = cos_entry(qn - r, n, tw);
    case (e / qn)
      0:       return -b;
      1:       return -a;
      2:       return b;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/fft_r22sdf_twiddle_gen_rom.sv
// Synchronous-read twiddle ROM. By default a dual-port quarter-wave cosine
// table of FFT_N/4+1 entries; with FFT_TWIDDLE_FULL_ROM_EN defined, a
// single-port table of FFT_N packed {re,im} words indexed by the exponent.
// Contents are computed at elaboration.
module fft_twiddle_rom
  import fft_r22sdf_pkg::*;
#(
  parameter int    TW            = 10,
  parameter int    FFT_N         = 1024,
  parameter int    NLOG2         = 10,
  parameter string ROM_INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                rst_n,
`ifdef FFT_TWIDDLE_FULL_ROM_EN
  input  logic [NLOG2-1:0]    addr,
  output logic [2*TW-1:0]     data
`else
  input  logic [NLOG2-2:0]    addr_a,
  input  logic [NLOG2-2:0]    addr_b,
  output logic [TW-1:0]       data_a,
  output logic [TW-1:0]       data_b
`endif
);

`ifdef FFT_TWIDDLE_FULL_ROM_EN

  logic [2*TW-1:0] rom [0:FFT_N-1];

  for (genvar k = 0; k < FFT_N; k++) begin : g_entry
    localparam int RE = full_re(k, FFT_N, TW);
    localparam int IM = full_im(k, FFT_N, TW);
    assign rom[k] = {RE[TW-1:0], IM[TW-1:0]};
  end

  // Registered single-port read of the complex word.
  always_ff @(posedge clk_i) begin
    if (!rst_n) data <= '0;
    else        data <= rom[addr];
  end

`else

  localparam int QN = FFT_N / 4;

  logic [TW-1:0] rom [0:QN];

  for (genvar k = 0; k <= QN; k++) begin : g_entry
    localparam int CK = cos_entry(k, FFT_N, TW);
    assign rom[k] = CK[TW-1:0];
  end

  // Registered dual-port read: A = C[r], B = C[FFT_N/4 - r].
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

`endif

endmodule

// File: rtl/fft_r22sdf_twiddle_gen.sv
// Twiddle-factor source for one R2^2 SDF twiddle-multiply stage.
// Three-stage pipeline: exponent, ROM read, fold/output register.
// Optional build macro: FFT_TWIDDLE_FULL_ROM_EN (full complex table, no fold).
module fft_r22sdf_twiddle_gen
  import fft_r22sdf_pkg::*;
#(
  parameter int    TWIDDLE_WIDTH = 10,
  parameter int    FFT_N         = 1024,
  parameter int    NLOG2         = 10,
  parameter string ROM_INIT_FILE = ""
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic [NLOG2-1:0]                ctr_i,
  output logic                            valid_o,
  output logic [NLOG2-1:0]                ctr_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

  localparam int TW = TWIDDLE_WIDTH;
  localparam logic signed [TW-1:0] W_ONE = TW'(tw_max(TW));

  // Stage 0 decode: quadrant digit and in-quadrant index of the sample.
  logic [1:0]       q_in;
  logic [NLOG2-1:0] m_ext;
  logic [NLOG2-1:0] e_in;

  assign q_in  = ctr_i[NLOG2-1:NLOG2-2];
  assign m_ext = {2'b00, ctr_i[NLOG2-3:0]};

  // Exponent e = m * bitrev2(q) with shifts and one add.
  always_comb begin
    e_in = '0;
    case (bitrev2(q_in))
      2'd0:    e_in = '0;
      2'd1:    e_in = m_ext;
      2'd2:    e_in = m_ext << 1;
      default: e_in = (m_ext << 1) + m_ext;
    endcase
  end

  // Stage 1 registers.
  logic             valid1;
  logic [NLOG2-1:0] ctr1;
  logic [NLOG2-1:0] e1;

  // Stage 1: capture exponent alongside the sample it belongs to.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid1 <= 1'b0;
      ctr1   <= '0;
      e1     <= '0;
    end else begin
      valid1 <= valid_i;
      ctr1   <= ctr_i;
      e1     <= e_in;
    end
  end

  // Stage 2 sideband registers (data registers live inside the ROM).
  logic             valid2;
  logic [NLOG2-1:0] ctr2;

`ifdef FFT_TWIDDLE_FULL_ROM_EN

  logic [2*TW-1:0] word2;

  fft_twiddle_rom #(
    .TW            (TW),
    .FFT_N         (FFT_N),
    .NLOG2         (NLOG2),
    .ROM_INIT_FILE (ROM_INIT_FILE)
  ) u_rom (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .addr  (e1),
    .data  (word2)
  );

  // Stage 2: delay valid/ctr to line up with the ROM word.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid2 <= 1'b0;
      ctr2   <= '0;
    end else begin
      valid2 <= valid1;
      ctr2   <= ctr1;
    end
  end

  // Stage 3: register the table word straight onto the outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      ctr_o   <= '0;
      w_re_o  <= W_ONE;
      w_im_o  <= '0;
    end else begin
      valid_o <= valid2;
      ctr_o   <= ctr2;
      w_re_o  <= signed'(word2[2*TW-1:TW]);
      w_im_o  <= signed'(word2[TW-1:0]);
    end
  end

`else

  localparam logic [NLOG2-2:0] QN_ADDR = (NLOG2-1)'(FFT_N / 4);

  logic [1:0]       qe1;
  logic [NLOG2-2:0] addr_a;
  logic [NLOG2-2:0] addr_b;
  logic [TW-1:0]    a2;
  logic [TW-1:0]    b2;
  logic [1:0]       qe2;

  // r = e mod FFT_N/4 is the low bits of e; qe is its top digit.
  assign qe1    = e1[NLOG2-1:NLOG2-2];
  assign addr_a = {1'b0, e1[NLOG2-3:0]};
  assign addr_b = QN_ADDR - addr_a;

  fft_twiddle_rom #(
    .TW            (TW),
    .FFT_N         (FFT_N),
    .NLOG2         (NLOG2),
    .ROM_INIT_FILE (ROM_INIT_FILE)
  ) u_rom (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .data_a (a2),
    .data_b (b2)
  );

  // Stage 2: delay valid/ctr/quadrant to line up with the ROM reads.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid2 <= 1'b0;
      ctr2   <= '0;
      qe2    <= '0;
    end else begin
      valid2 <= valid1;
      ctr2   <= ctr1;
      qe2    <= qe1;
    end
  end

  logic signed [TW-1:0] a_s;
  logic signed [TW-1:0] b_s;
  logic signed [TW-1:0] fold_re;
  logic signed [TW-1:0] fold_im;

  assign a_s = signed'(a2);
  assign b_s = signed'(b2);

  // Quadrant fold; table entries never exceed tw_max, so negation cannot
  // reach the most negative code, and negating a zero entry stays zero.
  always_comb begin
    fold_re = a_s;
    fold_im = -b_s;
    case (qe2)
      2'd0: begin fold_re = a_s;  fold_im = -b_s; end
      2'd1: begin fold_re = -b_s; fold_im = -a_s; end
      2'd2: begin fold_re = -a_s; fold_im = b_s;  end
      default: begin fold_re = b_s; fold_im = a_s; end
    endcase
  end

  // Stage 3: register folded twiddle and its aligned sideband.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      ctr_o   <= '0;
      w_re_o  <= W_ONE;
      w_im_o  <= '0;
    end else begin
      valid_o <= valid2;
      ctr_o   <= ctr2;
      w_re_o  <= fold_re;
      w_im_o  <= fold_im;
    end
  end

`endif

endmodule

// File: tb/tb_fft_r22sdf_twiddle_gen.sv
// Directed bench for fft_r22sdf_twiddle_gen at FFT_N=16, TW=10.
// Expected twiddles are hand-computed from the 16-point table.
module tb_fft_r22sdf_twiddle_gen;

  localparam int TW = 10;
  localparam int N  = 16;
  localparam int NL = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_n;
  logic                 valid_i;
  logic [NL-1:0]        ctr_i;
  logic                 valid_o;
  logic [NL-1:0]        ctr_o;
  logic signed [TW-1:0] w_re_o;
  logic signed [TW-1:0] w_im_o;

  int checks  = 0;
  int errors  = 0;
  int step_no = 0;

  // Samples currently in flight since the last reset, oldest first.
  logic          hist_v [$];
  logic [NL-1:0] hist_c [$];

  // Hand-computed W for each ctr value n (e from R2^2 ordering).
  // C = {511, 473, 362, 196, 0} for k = 0..4.
  int exp_re_tab [N] = '{511, 511, 511, 511,
                         511, 362,   0, -362,
                         511, 473, 362,  196,
                         511, 196, -362, -473};
  int exp_im_tab [N] = '{  0,    0,    0,    0,
                           0, -362, -511, -362,
                           0, -196, -362, -473,
                           0, -473, -362,  196};

  fft_r22sdf_twiddle_gen #(
    .TWIDDLE_WIDTH (TW),
    .FFT_N         (N),
    .NLOG2         (NL),
    .ROM_INIT_FILE ("")
  ) dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .ctr_i   (ctr_i),
    .valid_o (valid_o),
    .ctr_o   (ctr_o),
    .w_re_o  (w_re_o),
    .w_im_o  (w_im_o)
  );

  // Free-running stage clock.
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic ev, input logic [NL-1:0] ec,
                              input logic signed [TW-1:0] er, input logic signed [TW-1:0] ei,
                              input logic chk_data);
    checks++;
    assert (valid_o === ev) else begin
      errors++;
      $error("FAIL %s valid_o: observed=%0b expected=%0b", tag, valid_o, ev);
    end
    if (ev || chk_data) begin
      checks++;
      assert (ctr_o === ec) else begin
        errors++;
        $error("FAIL %s ctr_o: observed=%0d expected=%0d", tag, ctr_o, ec);
      end
      checks++;
      assert (w_re_o === er) else begin
        errors++;
        $error("FAIL %s w_re_o: observed=%0d expected=%0d", tag, w_re_o, er);
      end
      checks++;
      assert (w_im_o === ei) else begin
        errors++;
        $error("FAIL %s w_im_o: observed=%0d expected=%0d", tag, w_im_o, ei);
      end
    end
  endtask

  // Drive one cycle of inputs, then check the output that is due now.
  task automatic apply_stimulus(input logic r, input logic v, input logic [NL-1:0] c);
    string tag;
    int    idx;
    rst_n   = r;
    valid_i = v;
    ctr_i   = c;
    @(posedge clk_i);
    #1;
    step_no++;
    tag = $sformatf("step%0d", step_no);
    if (!r) begin
      hist_v.delete();
      hist_c.delete();
      check_output({tag, "_reset"}, 1'b0, '0, TW'(511), TW'(0), 1'b1);
    end else begin
      hist_v.push_back(v);
      hist_c.push_back(c);
      if (hist_v.size() >= 3) begin
        idx = hist_v.size() - 3;
        check_output(tag, hist_v[idx], hist_c[idx],
                     TW'(exp_re_tab[hist_c[idx]]), TW'(exp_im_tab[hist_c[idx]]), 1'b0);
      end else begin
        check_output({tag, "_fill"}, 1'b0, '0, TW'(0), TW'(0), 1'b0);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ctr_i   = '0;
    @(posedge clk_i);
    #1;

    // Reset state.
    apply_stimulus(1'b0, 1'b1, 4'd9);

    // Single sample ctr=0, then idle: W=1 after three cycles.
    apply_stimulus(1'b1, 1'b1, 4'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0);

    // Directed exponents 2, 3, 6, 9 with a gap.
    apply_stimulus(1'b1, 1'b1, 4'd5);
    apply_stimulus(1'b1, 1'b1, 4'd13);
    apply_stimulus(1'b1, 1'b0, 4'd3);
    apply_stimulus(1'b1, 1'b1, 4'd7);
    apply_stimulus(1'b1, 1'b1, 4'd15);

    // Full back-to-back section, then wrap to 0 without a bubble.
    for (int n = 0; n < N; n++) apply_stimulus(1'b1, 1'b1, NL'(n));
    apply_stimulus(1'b1, 1'b1, 4'd0);
    apply_stimulus(1'b1, 1'b1, 4'd1);
    apply_stimulus(1'b1, 1'b1, 4'd2);

    // One-cycle reset mid-stream discards in-flight samples.
    apply_stimulus(1'b0, 1'b1, 4'd6);
    apply_stimulus(1'b1, 1'b1, 4'd6);
    apply_stimulus(1'b1, 1'b1, 4'd9);
    apply_stimulus(1'b1, 1'b1, 4'd14);
    apply_stimulus(1'b1, 1'b0, 4'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0);
    apply_stimulus(1'b1, 1'b0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
